// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control bus between instruction fetch/datapath and the main control FSM
//
// Purpose: groups the control FSM's enable, its instruction inputs and every strobe it drives.
// Port summary:
//   en, opCode, m, takeBranch : driven by master (instruction buffer / datapath / harness)
//   instType                  : instruction-buffer format decode
//   irWrite, pcWrite, pcSrc   : fetch / PC update controls
//   aluSrc, aluOp             : ALU operand and operation selects
//   memRD, memWE              : data-memory read / write
//   byteLoad, extSigned       : byte-load and sign-extension selects
//   BusWE, R0, R7, wbSel      : register-file write, operand-1 R0 select, link write, writeback select
//   state, instDone, instCount: FSM status and retired-instruction counter
interface multicycle_control_if;
  logic        en;
  logic [3:0]  opCode;
  logic        m;
  logic        takeBranch;
  logic [1:0]  instType;
  logic        irWrite;
  logic        pcWrite;
  logic [1:0]  pcSrc;
  logic        aluSrc;
  logic [1:0]  aluOp;
  logic        memRD;
  logic        memWE;
  logic        byteLoad;
  logic        extSigned;
  logic        BusWE;
  logic        R0;
  logic        R7;
  logic [1:0]  wbSel;
  logic [2:0]  state;
  logic        instDone;
  logic [15:0] instCount;

  modport master (
    output en, opCode, m, takeBranch,
    input  instType, irWrite, pcWrite, pcSrc, aluSrc, aluOp, memRD, memWE,
           byteLoad, extSigned, BusWE, R0, R7, wbSel, state, instDone, instCount
  );

  modport slave (
    input  en, opCode, m, takeBranch,
    output instType, irWrite, pcWrite, pcSrc, aluSrc, aluOp, memRD, memWE,
           byteLoad, extSigned, BusWE, R0, R7, wbSel, state, instDone, instCount
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle main control FSM for the 16-bit RISC core
//
// Purpose: sequences each instruction through IF/ID/EX/MEM/WB, drives datapath strobes
// combinationally from state/opCode/m, and counts retired instructions.
// Port summary:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : multicycle_control_if.slave (inputs en/opCode/m/takeBranch, all strobes and status out)
module multicycle_control (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_control_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_inst_count;

  // Opcode classes
  logic w_is_rtype, w_is_itype, w_is_load, w_is_store, w_is_branch, w_is_jump;
  logic w_is_lb, w_is_jmp, w_is_call, w_is_ret;

  // Raw (ungated) strobes and selects from the decode
  logic       w_ir, w_pw, w_mr, w_mw, w_bw, w_r7, w_done;
  logic       w_as, w_bl, w_es, w_r0;
  logic [1:0] w_ps, w_ao, w_ws;
  logic       w_live;

  assign w_is_rtype  = (bus.opCode <= 4'd2);
  assign w_is_itype  = (bus.opCode == 4'd3) || (bus.opCode == 4'd4);
  assign w_is_load   = (bus.opCode == 4'd5) || (bus.opCode == 4'd6);
  assign w_is_lb     = (bus.opCode == 4'd6);
  assign w_is_store  = (bus.opCode == 4'd7) || (bus.opCode == 4'd15);
  assign w_is_branch = (bus.opCode >= 4'd8) && (bus.opCode <= 4'd11);
  assign w_is_jmp    = (bus.opCode == 4'd12);
  assign w_is_call   = (bus.opCode == 4'd13);
  assign w_is_ret    = (bus.opCode == 4'd14);
  assign w_is_jump   = w_is_jmp || w_is_call || w_is_ret;

  // Instruction-buffer format: SV is the only S-type; loads, SW and branches use the I layout
  always_comb begin
    bus.instType = 2'b01;
    if (w_is_rtype)
      bus.instType = 2'b00;
    else if (w_is_jump)
      bus.instType = 2'b10;
    else if (bus.opCode == 4'd15)
      bus.instType = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IF;
      r_inst_count <= 16'd0;
    end else if (bus.en) begin
      r_state <= w_next;
      if (w_done)
        r_inst_count <= r_inst_count + 16'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    w_ir   = 1'b0;
    w_pw   = 1'b0;
    w_ps   = 2'b00;
    w_as   = 1'b0;
    w_ao   = 2'b00;
    w_mr   = 1'b0;
    w_mw   = 1'b0;
    w_bl   = 1'b0;
    w_es   = 1'b0;
    w_bw   = 1'b0;
    w_r0   = 1'b0;
    w_r7   = 1'b0;
    w_ws   = 2'b00;
    w_done = 1'b0;
    case (r_state)
      S_IF: begin
        w_ir   = 1'b1;
        w_pw   = 1'b1;
        w_next = S_ID;
      end
      S_ID: begin
        w_r0 = w_is_branch && bus.m;
        if (w_is_jump) begin
          // PC already holds PC+2 from IF, so CALL links the correct return address
          w_pw   = 1'b1;
          w_ps   = w_is_ret ? 2'b11 : 2'b10;
          w_r7   = w_is_call;
          w_ws   = w_is_call ? 2'b10 : 2'b00;
          w_done = 1'b1;
          w_next = S_IF;
        end else begin
          w_next = S_EX;
        end
      end
      S_EX: begin
        if (w_is_branch) begin
          w_ao   = 2'b10;
          w_ps   = 2'b01;
          w_pw   = bus.takeBranch;
          w_done = 1'b1;
          w_next = S_IF;
        end else begin
          w_as = w_is_itype || w_is_load || w_is_store;
          if (bus.opCode == 4'd2)
            w_ao = 2'b10;
          else if ((bus.opCode == 4'd0) || (bus.opCode == 4'd4))
            w_ao = 2'b00;
          else
            w_ao = 2'b01;
          w_next = (w_is_load || w_is_store) ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        w_mr = w_is_load;
        w_mw = w_is_store;
        if (w_is_store) begin
          w_done = 1'b1;
          w_next = S_IF;
        end else begin
          w_next = S_WB;
        end
      end
      S_WB: begin
        w_bw   = 1'b1;
        w_ws   = w_is_load ? 2'b01 : 2'b00;
        w_bl   = w_is_lb;
        w_es   = w_is_lb && bus.m;
        w_done = 1'b1;
        w_next = S_IF;
      end
      default: w_next = S_IF;
    endcase
  end

  // Write strobes and instDone only fire when the FSM actually advances; selects stay decoded
  assign w_live = bus.en && !rst;

  assign bus.irWrite   = w_ir && w_live;
  assign bus.pcWrite   = w_pw && w_live;
  assign bus.memRD     = w_mr && w_live;
  assign bus.memWE     = w_mw && w_live;
  assign bus.BusWE     = w_bw && w_live;
  assign bus.R7        = w_r7 && w_live;
  assign bus.instDone  = w_done && w_live;
  assign bus.pcSrc     = w_ps;
  assign bus.aluSrc    = w_as;
  assign bus.aluOp     = w_ao;
  assign bus.byteLoad  = w_bl;
  assign bus.extSigned = w_es;
  assign bus.R0        = w_r0;
  assign bus.wbSel     = w_ws;
  assign bus.state     = r_state;
  assign bus.instCount = r_inst_count;

endmodule
